if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset; it shall be word-aligned.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, is the instruction value inserted on reset or flush.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 freeze  input  1  hazard stall: hold PC and hold the IF/ID register.
REQ-006 branch_taken  input  1  redirect PC to branch_addr on the next edge.
REQ-007 branch_addr  input  32  byte address of the branch target.
REQ-008 flush  input  1  replace the IF/ID contents with a bubble on the next edge.
REQ-009 imem_addr  output  32  byte address to the instruction memory; equals the current PC.
REQ-010 imem_data  input  32  instruction word from the instruction memory, combinational from imem_addr (word index = imem_addr[31:2]).
REQ-011 pc_out  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-012 instruction  output  32  registered instruction held in IF/ID.
REQ-013 valid  output  1  registered; 1 when IF/ID holds a real fetched instruction, 0 for a bubble.

Function
REQ-014 The block shall hold a 32-bit PC register; imem_addr shall be driven combinationally from the PC.
REQ-015 PC next-value priority, highest first: rst -> RESET_PC; branch_taken -> {branch_addr[31:2],2'b00}; freeze -> hold; otherwise PC+4.
REQ-016 PC+4 shall wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag raised.
REQ-017 PC[1:0] shall always be 2'b00; branch_addr[1:0] shall be ignored.
REQ-018 IF/ID next-value priority, highest first: rst -> {NOP_WORD, 0, 0}; flush or branch_taken -> {instruction=NOP_WORD, pc_out=0, valid=0}; freeze -> hold all three; otherwise {instruction=imem_data, pc_out=PC+4, valid=1}.
REQ-019 Fetch latency shall be one cycle: the word addressed in cycle N appears on instruction in cycle N+1.
REQ-020 If branch_taken and freeze are both high, branch_taken shall win for both the PC and IF/ID (redirect plus bubble); the freeze shall take effect only once branch_taken is low.
REQ-021 If flush and freeze are both high, IF/ID shall take the bubble and the PC shall hold.
REQ-022 Freeze shall hold indefinitely with no loss or duplication: on release, fetching shall resume at the held PC.
REQ-023 There shall be no combinational path from any input to pc_out, instruction or valid.

Reset
REQ-024 With rst high at a rising edge, the PC shall become RESET_PC and IF/ID shall become instruction=NOP_WORD, pc_out=0, valid=0, whatever the other inputs are.
REQ-025 Reset asserted mid-stream (during freeze or branch) shall behave exactly as REQ-024; the first fetch after rst falls shall be from RESET_PC.
REQ-026 Before the first reset edge, state shall be undefined; the bench shall apply rst for at least 1 cycle.

Verification
REQ-027 Sequential fetch: rst 1 cycle, memory words 0..3 = A0..A3 -> instruction/pc_out show (A0,4), (A1,8), (A2,12), (A3,16) on consecutive cycles, valid=1.
REQ-028 Freeze: freeze high for 3 cycles while PC=8 -> imem_addr stays 8; instruction/pc_out/valid hold (A1,8,1); after release the next output is (A2,12).
REQ-029 Branch: branch_taken=1, branch_addr=32'h0000_0023 while PC=12 -> next cycle PC=32, IF/ID={NOP_WORD,0,0}; the cycle after shows (mem[8],36,1).
REQ-030 Simultaneous events: branch_taken+freeze -> PC=target and bubble; flush+freeze -> PC held and bubble; after flush falls with freeze still high, the bubble is held.
REQ-031 Wrap and reset: PC forced via branch to 32'hFFFF_FFFC -> next PC 0 and pc_out=0 with valid=1; assert rst during freeze -> PC=RESET_PC, valid=0.
REQ-032 Scoreboard: a reference model of REQ-015/REQ-018 shall run for 10k cycles of random freeze, flush and branch_taken with zero mismatches.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.
// Fetch is one cycle: the word addressed by the PC this cycle is latched into IF/ID at the next edge.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    // Wraps modulo 2^32 by construction; no carry is kept.
    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every signal gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        pc_d = pc_plus4;
        if (branch_taken) begin
            pc_d = {branch_addr[31:2], 2'b00};
        end else if (freeze) begin
            pc_d = pc_q;
        end
    end

    // A redirect or flush kills the word fetched this cycle; a freeze alone holds IF/ID.
    always_comb begin
        instr_d  = imem_data;
        pc_out_d = pc_plus4;
        valid_d  = 1'b1;
        if (flush || branch_taken) begin
            instr_d  = NOP_WORD;
            pc_out_d = 32'd0;
            valid_d  = 1'b0;
        end else if (freeze) begin
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            valid_d  = valid_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC_ALIGNED;
            instr_q  <= NOP_WORD;
            pc_out_q <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pc_out_q;
    assign instruction = instr_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by a long random run, all checked
// against a cycle-level reference model of the fetch rules.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_out;
    logic [31:0] instruction;
    logic        valid;

    int compared = 0;
    int mismatched = 0;

    // Reference state: PC and the IF/ID contents.
    logic [31:0] m_pc, m_instr, m_pc_out;
    logic        m_valid;
    bit          m_known = 0;

    always #5 clk = ~clk;

    // Instruction memory contents as a function of word index.
    function automatic logic [31:0] mem_word(input logic [29:0] idx);
        return 32'hC0DE_0000 ^ ({2'b00, idx} * 32'h0101_0107);
    endfunction

    assign imem_data = mem_word(imem_addr[31:2]);

    if_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .flush(flush),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .pc_out(pc_out),
        .instruction(instruction),
        .valid(valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the current inputs, then compare all outputs.
    task automatic tick();
        logic [31:0] fetched;
        if (m_known) check("imem_addr_pre", imem_addr, m_pc);
        fetched = mem_word(m_pc[31:2]);
        if (rst) begin
            m_pc = RESET_PC; m_instr = NOP_WORD; m_pc_out = 0; m_valid = 0;
            m_known = 1;
        end else begin
            if (branch_taken || flush) begin
                m_instr = NOP_WORD; m_pc_out = 0; m_valid = 0;
            end else if (!freeze) begin
                m_instr = fetched; m_pc_out = m_pc + 4; m_valid = 1;
            end
            if (branch_taken) m_pc = branch_addr & ~32'd3;
            else if (!freeze) m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
        check("pc", imem_addr, m_pc);
        check("instruction", instruction, m_instr);
        check("pc_out", pc_out, m_pc_out);
        check("valid", {31'd0, valid}, {31'd0, m_valid});
    endtask

    task automatic set_in(input logic r, input logic fz, input logic br,
                          input logic [31:0] ba, input logic fl);
        rst = r; freeze = fz; branch_taken = br; branch_addr = ba; flush = fl;
    endtask

    initial begin
        @(posedge clk); #1;

        // Reset state
        set_in(1, 0, 0, 0, 0); tick();
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instruction, NOP_WORD);

        // Sequential fetch
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("seq_instr", instruction, mem_word(30'(i)));
            check("seq_pc_out", pc_out, 32'(4 * (i + 1)));
        end

        // Freeze at PC=8
        set_in(1, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0); tick(); tick();
        check("frz_pc_start", imem_addr, 32'd8);
        set_in(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_addr", imem_addr, 32'd8);
            check("frz_instr", instruction, mem_word(30'd1));
            check("frz_pc_out", pc_out, 32'd8);
        end
        set_in(0, 0, 0, 0, 0); tick();
        check("frz_release", instruction, mem_word(30'd2));
        check("frz_release_pc", pc_out, 32'd12);

        // Branch from PC=12 with misaligned target
        set_in(0, 0, 1, 32'h0000_0023, 0); tick();
        check("br_pc", imem_addr, 32'd32);
        check("br_bubble", {31'd0, valid}, 32'd0);
        set_in(0, 0, 0, 0, 0); tick();
        check("br_target_instr", instruction, mem_word(30'd8));
        check("br_target_pc", pc_out, 32'd36);

        // Branch + freeze, flush + freeze, then freeze alone holds the bubble
        set_in(0, 1, 1, 32'h0000_0100, 0); tick();
        check("brfz_pc", imem_addr, 32'h100);
        set_in(0, 1, 0, 0, 1); tick();
        check("flfz_pc", imem_addr, 32'h100);
        check("flfz_valid", {31'd0, valid}, 32'd0);
        set_in(0, 1, 0, 0, 0); tick(); tick();
        check("fz_bubble_held", instruction, NOP_WORD);
        set_in(0, 0, 0, 0, 0); tick();
        check("resume_pc_out", pc_out, 32'h104);

        // Wrap past the top of the address space
        set_in(0, 0, 1, 32'hFFFF_FFFF, 0); tick();
        check("wrap_pc_top", imem_addr, 32'hFFFF_FFFC);
        set_in(0, 0, 0, 0, 0); tick();
        check("wrap_pc", imem_addr, 32'd0);
        check("wrap_pc_out", pc_out, 32'd0);
        check("wrap_valid", {31'd0, valid}, 32'd1);

        // Reset during freeze, then first fetch from RESET_PC
        set_in(0, 1, 0, 0, 0); tick();
        set_in(1, 1, 1, 32'h40, 1); tick();
        check("midrst_pc", imem_addr, RESET_PC);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        set_in(0, 0, 0, 0, 0); tick();
        check("postrst_instr", instruction, mem_word(RESET_PC[31:2]));

        // Random scoreboard run
        for (int c = 0; c < 10000; c++) begin
            logic [31:0] ba;
            ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            set_in($urandom_range(0, 99) == 0,
                   $urandom_range(0, 9) < 3,
                   $urandom_range(0, 9) == 0,
                   ba,
                   $urandom_range(0, 9) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
